// File: rtl/cs_pkg.sv
// cs_pkg: mode codes and width helpers shared by the CS window filter files
package cs_pkg;
  localparam logic [1:0] CS_APPR = 2'd0;
  localparam logic [1:0] CS_MEAN = 2'd1;
  localparam logic [1:0] CS_XAPPR = 2'd2;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int sum_w(input int dw, input int n);
    return dw + clog2(n + 1);
  endfunction
  function automatic int res_w(input int dw);
    return dw + 2;
  endfunction
  function automatic bit is_pow2(input int v);
    return (v & (v - 1)) == 0;
  endfunction
endpackage

// File: rtl/cs_appr_search.sv
// cs_appr_search: largest window entry not exceeding avg (0 if none qualifies)
//  win   in  N x DW  window entries
//  avg   in  DW      floor(sum/N)
//  xappr out DW      max{win[i] : win[i] <= avg}
module cs_appr_search #(
  parameter int DW = 8,
  parameter int N = 9
) (
  input  logic [N-1:0][DW-1:0] win,
  input  logic [DW-1:0]        avg,
  output logic [DW-1:0]        xappr
);
  always_comb begin
    xappr = '0;
    for (int i = 0; i < N; i++) xappr = (win[i] <= avg && win[i] > xappr) ? win[i] : xappr;
  end
endmodule

// File: rtl/cs_window_filter.sv
// cs_window_filter: sliding-window filter emitting APPR/MEAN/XAPPR per accepted sample
//  clk, reset (async, active-high)
//  in_valid, X, mode, flush   sample input, result mode, synchronous window clear
//  out_valid, Y, full         result strobe, registered result, window holds N samples
module cs_window_filter
  import cs_pkg::*;
#(
  parameter int DW = 8,
  parameter int N = 9,
  parameter bit WARMUP_GATE = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] X,
  input  logic [1:0]    mode,
  input  logic          flush,
  output logic          out_valid,
  output logic [DW+1:0] Y,
  output logic          full
);
  localparam int SW = sum_w(DW, N);
  localparam int CW = clog2(N + 1);
  localparam int RW = res_w(DW);
  localparam int AW = SW + 1;
  logic [N-1:0][DW-1:0] win, win_n;
  logic [SW-1:0] sum, sum_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DW-1:0] avg_n, xappr;
  logic [AW-1:0] num;
  logic [RW-1:0] y_appr, y_n;
  assign win_n = flush ? (N*DW)'(in_valid ? X : '0) : in_valid ? {win[N-2:0], X} : win;
  // sum always contains win[N-1], so the subtraction cannot underflow
  assign sum_n = flush ? (in_valid ? SW'(X) : '0) :
                 in_valid ? sum - SW'(win[N-1]) + SW'(X) : sum;
  assign cnt_n = flush ? CW'(in_valid) : (in_valid && cnt != CW'(N)) ? cnt + 1'b1 : cnt;
  assign avg_n = is_pow2(N) ? DW'(sum_n >> clog2(N)) : DW'(sum_n / SW'(N));
  cs_appr_search #(.DW(DW), .N(N)) u_search (.win(win_n), .avg(avg_n), .xappr(xappr));
  // Xappr*N + sum needs one bit beyond the sum width
  assign num = AW'(xappr) * AW'(N) + AW'(sum_n);
  assign y_appr = is_pow2(N - 1) ? RW'(num >> clog2(N - 1)) : RW'(num / AW'(N - 1));
  assign y_n = mode == CS_MEAN ? RW'(avg_n) : mode == CS_XAPPR ? RW'(xappr) : y_appr;
  assign full = cnt == CW'(N);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win <= '0;
      sum <= '0;
      cnt <= '0;
      Y <= '0;
      out_valid <= 1'b0;
    end else begin
      win <= win_n;
      sum <= sum_n;
      cnt <= cnt_n;
      out_valid <= in_valid && (cnt_n == CW'(N) || !WARMUP_GATE);
      if (in_valid) Y <= y_n;
    end
  end
endmodule

// File: tb/tb_cs_window_filter.sv
// tb_cs_window_filter: vector table plus scoreboard bench for cs_window_filter
module tb_cs_window_filter;
  import cs_pkg::*;
  localparam int DW = 8;
  localparam int N = 9;
  typedef struct {
    logic [7:0] x;
    logic [1:0] mode;
    bit         chk;
    bit         vld;
    int         y;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic flush = 1'b0;
  logic [DW-1:0] X = '0;
  logic [1:0] mode = '0;
  logic ov1, full1, ov0, full0;
  logic [DW+1:0] y1, y0;
  int n_tests = 0;
  int n_fail = 0;
  int mw[N];
  int mcnt;
  int ylast;
  int q1[$];
  int q0[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  cs_window_filter #(.DW(DW), .N(N), .WARMUP_GATE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .X(X), .mode(mode), .flush(flush),
    .out_valid(ov1), .Y(y1), .full(full1)
  );
  cs_window_filter #(.DW(DW), .N(N), .WARMUP_GATE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .X(X), .mode(mode), .flush(flush),
    .out_valid(ov0), .Y(y0), .full(full0)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic void add(input int x, input logic [1:0] m, input bit chk, input bit vld, input int y);
    vec_t v;
    v.x = 8'(x);
    v.mode = m;
    v.chk = chk;
    v.vld = vld;
    v.y = y;
    tbl.push_back(v);
  endfunction

  task automatic model_reset();
    foreach (mw[i]) mw[i] = 0;
    mcnt = 0;
    ylast = 0;
    q1.delete();
    q0.delete();
  endtask

  // reference: recomputes the sum from scratch each sample
  task automatic model_step(input bit v, input bit fl, input int x, input int m);
    int s, a, xa, y;
    if (fl) begin
      foreach (mw[i]) mw[i] = 0;
      mw[0] = v ? x : 0;
      mcnt = v ? 1 : 0;
    end else if (v) begin
      for (int i = N - 1; i > 0; i--) mw[i] = mw[i-1];
      mw[0] = x;
      if (mcnt < N) mcnt++;
    end
    if (!v) return;
    s = 0;
    foreach (mw[i]) s += mw[i];
    a = s / N;
    xa = 0;
    foreach (mw[i]) if (mw[i] <= a && mw[i] > xa) xa = mw[i];
    y = (m == 1) ? a : (m == 2) ? xa : (xa * N + s) / (N - 1);
    ylast = y;
    q0.push_back(y);
    if (mcnt == N) q1.push_back(y);
  endtask

  task automatic step(input bit v, input bit fl, input int x, input logic [1:0] m);
    in_valid = v;
    flush = fl;
    X = 8'(x);
    mode = m;
    model_step(v, fl, x & 255, int'(m));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    check("full1", int'(full1), int'(mcnt == N));
    check("full0", int'(full0), int'(mcnt == N));
  endtask

  always @(negedge clk) begin
    if (ov1) begin
      check("sb1_pending", int'(q1.size() != 0), 1);
      if (q1.size() != 0) check("sb1_y", int'(y1), q1.pop_front());
    end
    if (ov0) begin
      check("sb0_pending", int'(q0.size() != 0), 1);
      if (q0.size() != 0) check("sb0_y", int'(y0), q0.pop_front());
    end
  end

  initial begin
    int s2[9] = '{12, 15, 9, 21, 8, 14, 13, 10, 18};
    logic [1:0] m2[3] = '{CS_APPR, CS_MEAN, CS_XAPPR};
    int e2[3] = '{29, 13, 13};
    for (int i = 1; i <= 9; i++) add(i, CS_APPR, i == 1 || i >= 8, i == 9, 11);
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 9; i++) add(s2[i], m2[k], i == 8, 1'b1, e2[k]);
    for (int i = 0; i < 9; i++) add(255, CS_APPR, i == 8, 1'b1, 573);
    add(0, CS_APPR, 1'b1, 1'b1, 255);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_y", int'(y1), 0);
    check("rst_valid", int'(ov1), 0);
    check("rst_full", int'(full1), 0);
    reset = 1'b0;
    foreach (tbl[i]) begin
      step(1'b1, 1'b0, int'(tbl[i].x), tbl[i].mode);
      if (tbl[i].chk) begin
        check("tbl_valid", int'(ov1), int'(tbl[i].vld));
        if (tbl[i].vld) check("tbl_y", int'(y1), tbl[i].y);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 77, i == 1 ? CS_MEAN : CS_APPR);
      check("gap_valid", int'(ov1), 0);
      check("gap_y", int'(y1), ylast);
    end
    step(1'b1, 1'b0, 100, CS_APPR);
    check("gap_resume_valid", int'(ov1), 1);
    check("gap_resume_y", int'(y1), 348);
    step(1'b1, 1'b1, 40, CS_XAPPR);
    check("flush_nogate_valid", int'(ov0), 1);
    check("flush_nogate_y", int'(y0), 0);
    check("flush_nogate_full", int'(full0), 0);
    check("flush_gated_valid", int'(ov1), 0);
    step(1'b0, 1'b1, 0, CS_APPR);
    check("flush_idle_valid", int'(ov0), 0);
    step(1'b1, 1'b0, 50, CS_MEAN);
    check("post_flush_mean", int'(y0), 5);
    step(1'b1, 1'b0, 7, CS_APPR);
    step(1'b1, 1'b0, 7, CS_APPR);
    #6 reset = 1'b1;
    #1;
    check("async_rst_y", int'(y1), 0);
    check("async_rst_valid", int'(ov1), 0);
    check("async_rst_full", int'(full1), 0);
    check("async_rst_y0", int'(y0), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 1'b0, i, CS_APPR);
      if (i >= 8) check("restart_valid", int'(ov1), int'(i == 9));
      if (i == 9) check("restart_y", int'(y1), 11);
    end
    @(negedge clk);
    #1;
    check("sb1_drain", q1.size(), 0);
    check("sb0_drain", q0.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
